// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  // EMPTY: buffer free; HELD: result waiting; FORCE: result waiting, stall requested
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HELD  = 2'd1,
    FORCE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding register for a multi-cycle result plus the saturating
// counter of cycles it has been blocked from the write port.
module wb_hold_buf #(
  parameter int WIDTH    = 32,
  parameter int RD_W     = 5,
  parameter int MAX_WAIT = 4,
  localparam int CW      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             bump,
  input  logic [RD_W-1:0]  in_rd,
  input  logic [WIDTH-1:0] in_data,
  output logic [RD_W-1:0]  rd,
  output logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] SAT = CW'(MAX_WAIT);

  // Destination register and wait counter; load restarts the count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd    <= '0;
      count <= '0;
    end else if (load) begin
      rd    <= in_rd;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (bump && count != SAT) begin
      count <= count + 1'b1;
    end
  end

  // Data payload; only observed while the owning FSM marks the entry valid.
  // NOTE: the data word is deliberately left out of reset -- validity lives in
  // the FSM, so resetting this wide register would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (load) begin
      data <= in_data;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the W stage (always first) and
// a buffered multi-cycle result; requests a pipeline stall when the buffered
// result has been starved for MAX_WAIT cycles.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_AW   = wb_pkg::REG_AW,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [WIDTH-1:0]  ResultW,
  input  logic              McValid,
  input  logic [REG_AW-1:0] McRd,
  input  logic [WIDTH-1:0]  McData,
  output logic              McReady,
  output logic              RegWriteRF,
  output logic [REG_AW-1:0] RdRF,
  output logic [WIDTH-1:0]  WDataRF,
  output logic              StallReq,
  output logic              PendValid,
  output logic [REG_AW-1:0] PendRd,
  output logic              SquashW
);

  localparam logic [REG_AW-1:0] NO_REG = REG_AW'(ZERO_REG);

  wb_state_e         state, state_nxt;
  logic              pw, buf_valid, squash, drain, blocked, accept, load;
  logic              limit_hit;
  logic [REG_AW-1:0] buf_rd;
  logic [WIDTH-1:0]  buf_data;
  logic [3:0]        buf_count;

  // A write to the zero register never occupies the port.
  assign pw        = RegWriteW && (RdW != NO_REG);
  assign buf_valid = (state != EMPTY);
  assign squash    = buf_valid && pw && (RdW == buf_rd);
  assign drain     = buf_valid && !pw;
  assign blocked   = buf_valid && pw && !squash;
  assign accept    = McValid && (state == EMPTY);
  assign load      = accept && (McRd != NO_REG);
  assign limit_hit = ({1'b0, buf_count} + 5'd1) >= 5'(MAX_WAIT);

  wb_hold_buf #(
    .WIDTH   (WIDTH),
    .RD_W    (REG_AW),
    .MAX_WAIT(MAX_WAIT)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .clear  (squash || drain),
    .bump   (blocked),
    .in_rd  (McRd),
    .in_data(McData),
    .rd     (buf_rd),
    .data   (buf_data),
    .count  (buf_count)
  );

  // Next-state selection; the younger pipeline write wins a WAW conflict.
  // NOTE: every branch of this block assigns state_nxt via the default first,
  // so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:   if (load) state_nxt = HELD;
      HELD: begin
        if (drain || squash)        state_nxt = EMPTY;
        else if (blocked && limit_hit) state_nxt = FORCE;
      end
      FORCE:   if (drain || squash) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // State register with registered Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      McReady   <= 1'b1;
      StallReq  <= 1'b0;
      PendValid <= 1'b0;
    end else begin
      state     <= state_nxt;
      McReady   <= (state_nxt == EMPTY);
      StallReq  <= (state_nxt == FORCE);
      PendValid <= (state_nxt != EMPTY);
    end
  end

  // Write-port mux: pipeline, then buffered result, else idle.
  always_comb begin
    RegWriteRF = 1'b0;
    RdRF       = RdW;
    WDataRF    = ResultW;
    if (pw) begin
      RegWriteRF = 1'b1;
    end else if (buf_valid) begin
      RegWriteRF = 1'b1;
      RdRF       = buf_rd;
      WDataRF    = buf_data;
    end
  end

  assign PendRd  = buf_valid ? buf_rd : NO_REG;
  assign SquashW = squash;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all checked
// against a behavioural model of the one-entry pending result.
module tb_wb_port_arbiter;

  localparam int WIDTH    = 32;
  localparam int REG_AW   = 5;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              RegWriteW;
  logic [REG_AW-1:0] RdW;
  logic [WIDTH-1:0]  ResultW;
  logic              McValid;
  logic [REG_AW-1:0] McRd;
  logic [WIDTH-1:0]  McData;
  logic              McReady, RegWriteRF, StallReq, PendValid, SquashW;
  logic [REG_AW-1:0] RdRF, PendRd;
  logic [WIDTH-1:0]  WDataRF;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .WIDTH   (WIDTH),
    .REG_AW  (REG_AW),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RegWriteW (RegWriteW),
    .RdW       (RdW),
    .ResultW   (ResultW),
    .McValid   (McValid),
    .McRd      (McRd),
    .McData    (McData),
    .McReady   (McReady),
    .RegWriteRF(RegWriteRF),
    .RdRF      (RdRF),
    .WDataRF   (WDataRF),
    .StallReq  (StallReq),
    .PendValid (PendValid),
    .PendRd    (PendRd),
    .SquashW   (SquashW)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: is a result pending, where to, and how long it was starved.
  bit                m_pend;
  logic [REG_AW-1:0] m_rd;
  logic [WIDTH-1:0]  m_data;
  int                m_run;

  task automatic model_reset();
    m_pend = 0;
    m_rd   = '0;
    m_data = '0;
    m_run  = 0;
  endtask

  function automatic bit pipe_writes();
    return RegWriteW && (RdW != 0);
  endfunction

  task automatic check_model(input string ctx);
    bit pw;
    pw = pipe_writes();
    check({ctx, ".ready"}, McReady, !m_pend);
    check({ctx, ".pvalid"}, PendValid, m_pend);
    check({ctx, ".prd"}, PendRd, m_pend ? m_rd : '0);
    check({ctx, ".stall"}, StallReq, m_pend && (m_run >= MAX_WAIT));
    check({ctx, ".squash"}, SquashW, m_pend && pw && (RdW == m_rd));
    if (pw) begin
      check({ctx, ".we"}, RegWriteRF, 1);
      check({ctx, ".rd"}, RdRF, RdW);
      check({ctx, ".wd"}, WDataRF, ResultW);
    end else if (m_pend) begin
      check({ctx, ".we"}, RegWriteRF, 1);
      check({ctx, ".rd"}, RdRF, m_rd);
      check({ctx, ".wd"}, WDataRF, m_data);
    end else begin
      check({ctx, ".we"}, RegWriteRF, 0);
      check({ctx, ".rd"}, RdRF, RdW);
      check({ctx, ".wd"}, WDataRF, ResultW);
    end
  endtask

  task automatic model_edge();
    bit pw;
    pw = pipe_writes();
    if (rst) begin
      model_reset();
    end else if (m_pend) begin
      if (!pw || RdW == m_rd) begin
        m_pend = 0;
        m_run  = 0;
      end else if (m_run < MAX_WAIT) begin
        m_run++;
      end
    end else if (McValid && McRd != 0) begin
      m_pend = 1;
      m_rd   = McRd;
      m_data = McData;
      m_run  = 0;
    end
  endtask

  // Drive inputs (called just after a falling edge) and settle.
  task automatic drive(input bit we, input logic [REG_AW-1:0] rd, input logic [WIDTH-1:0] res,
                       input bit mv, input logic [REG_AW-1:0] mrd, input logic [WIDTH-1:0] mdat);
    RegWriteW = we;
    RdW       = rd;
    ResultW   = res;
    McValid   = mv;
    McRd      = mrd;
    McData    = mdat;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic tick(input string ctx);
    check_model(ctx);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    idle();
    check("reset.ready", McReady, 1);
    check("reset.stall", StallReq, 0);
    check("reset.pvalid", PendValid, 0);
    check("reset.prd", PendRd, 0);
    tick("reset");
    rst = 1'b0;

    // Free port: result written the cycle after it is accepted.
    drive(0, 0, 32'h0, 1, 3, 32'hDEADBEEF);
    tick("lat.accept");
    idle();
    check("lat.we", RegWriteRF, 1);
    check("lat.rd", RdRF, 3);
    check("lat.wd", WDataRF, 32'hDEADBEEF);
    tick("lat.write");
    idle();
    check("lat.pvalid_after", PendValid, 0);
    tick("lat.idle");

    // Priority and forced stall.
    drive(0, 0, 32'h0, 1, 7, 32'h7777_0007);
    tick("force.accept");
    for (int i = 0; i < MAX_WAIT; i++) begin
      drive(1, 9, 32'h900 + i, 0, 0, 32'h0);
      check("force.pipe_rd", RdRF, 9);
      check("force.no_stall_yet", StallReq, 0);
      tick("force.block");
    end
    drive(1, 9, 32'h999, 0, 0, 32'h0);
    check("force.stall_up", StallReq, 1);
    check("force.pipe_still_wins", RdRF, 9);
    tick("force.persist");
    idle();
    check("force.stall_held", StallReq, 1);
    check("force.drain_rd", RdRF, 7);
    check("force.drain_wd", WDataRF, 32'h7777_0007);
    tick("force.drain");
    idle();
    check("force.stall_clear", StallReq, 0);
    tick("force.idle");

    // WAW squash: pipeline write to the same register wins; buffer discarded.
    drive(0, 0, 32'h0, 1, 12, 32'hAAAA_AAAA);
    tick("waw.accept");
    drive(1, 12, 32'h55, 0, 0, 32'h0);
    check("waw.squash", SquashW, 1);
    check("waw.rd", RdRF, 12);
    check("waw.wd", WDataRF, 32'h55);
    tick("waw.hit");
    idle();
    check("waw.squash_gone", SquashW, 0);
    check("waw.no_write", RegWriteRF, 0);
    check("waw.ready", McReady, 1);
    tick("waw.idle");

    // Zero register handling.
    drive(0, 0, 32'h0, 1, 0, 32'h1234);
    tick("zero.accept");
    idle();
    check("zero.ready", McReady, 1);
    check("zero.no_write", RegWriteRF, 0);
    tick("zero.idle");
    drive(0, 0, 32'h0, 1, 4, 32'h44);
    tick("zero.load4");
    drive(1, 0, 32'h99, 0, 0, 32'h0);
    check("zero.drain_rd", RdRF, 4);
    check("zero.drain_wd", WDataRF, 32'h44);
    tick("zero.drain");
    idle();
    check("zero.pvalid", PendValid, 0);
    tick("zero.idle2");

    // Back-pressure: second result waits for the first to drain.
    drive(0, 0, 32'h0, 1, 6, 32'h66);
    tick("bp.first");
    for (int i = 0; i < 2; i++) begin
      drive(1, 10, 32'hA0 + i, 1, 8, 32'h88);
      check("bp.not_ready", McReady, 0);
      tick("bp.block");
    end
    drive(0, 0, 32'h0, 1, 8, 32'h88);
    check("bp.drain_rd", RdRF, 6);
    check("bp.not_ready_drain", McReady, 0);
    tick("bp.drain");
    drive(0, 0, 32'h0, 1, 8, 32'h88);
    check("bp.ready", McReady, 1);
    tick("bp.accept2");
    drive(1, 10, 32'hB0, 0, 0, 32'h0);
    tick("bp.block2");
    idle();
    check("bp.second_rd", RdRF, 8);
    check("bp.second_wd", WDataRF, 32'h88);
    tick("bp.write2");

    // Asynchronous reset while a result for x5 is held.
    drive(0, 0, 32'h0, 1, 5, 32'h5555);
    tick("rst.load5");
    drive(1, 9, 32'h1, 0, 0, 32'h0);
    tick("rst.block");
    RegWriteW = 1'b0;
    rst = 1'b1;
    #1;
    check("rst.ready", McReady, 1);
    check("rst.pvalid", PendValid, 0);
    check("rst.stall", StallReq, 0);
    check("rst.no_write", RegWriteRF, 0);
    model_reset();
    tick("rst.held");
    rst = 1'b0;
    idle();
    check("rst.no_x5", RegWriteRF, 0);
    tick("rst.after");

    // Random traffic with a narrow register range to provoke conflicts.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 70, REG_AW'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, REG_AW'($urandom_range(0, 7)), $urandom);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the pipeline W stage and one multi-cycle execution unit (iterative mul/div).
- W stage writes its selected writeback value (ALU, load or PC+4, chosen by the result-select mux) and always has priority.
- A completed multi-cycle result waits in a one-entry buffer until the port is free.
- If the wait grows too long, the block asks the hazard unit to stall the pipeline so the buffered result can drain.

Parameters:
- WIDTH, 32, data width of the write port.
- REG_AW, 5, register address width.
- MAX_WAIT, 4, blocked cycles allowed before a stall is requested; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- RegWriteW  in  1  W-stage register write enable.
- RdW  in  REG_AW  W-stage destination register.
- ResultW  in  WIDTH  W-stage writeback value from the result-select mux.
- McValid  in  1  multi-cycle unit result valid.
- McRd  in  REG_AW  multi-cycle destination register.
- McData  in  WIDTH  multi-cycle result.
- McReady  out  1  buffer can accept a result.
- RegWriteRF  out  1  register-file write enable.
- RdRF  out  REG_AW  register-file write address.
- WDataRF  out  WIDTH  register-file write data.
- StallReq  out  1  to hazard unit: freeze F–M and bubble W next cycle.
- PendValid  out  1  buffer holds an unwritten result (for hazard detection).
- PendRd  out  REG_AW  destination register of the buffered result.
- SquashW  out  1  one-cycle pulse: buffered result discarded because of a WAW conflict.

Behaviour:
- Single clock clk. Reset rst is asynchronous and active-high. State and counters are cleared immediately on assertion.
- Reset values: state EMPTY, wait count 0, buffer invalid. Hence McReady=1, StallReq=0, PendValid=0, PendRd=0, SquashW=0.
- Combinational port outputs (RegWriteRF, RdRF, WDataRF) follow the W-stage inputs from reset.
- Pipeline write "PW" = RegWriteW && RdW!=0. A write to RdW==0 counts as a free port.
- States:
  - EMPTY: McReady=1.
  - HELD: buffer valid.
  - FORCE: buffer valid and StallReq=1.
  - StallReq is a Moore output: 1 only in FORCE.
- Accept rule:
  - McValid && McReady at edge t loads the buffer (rd, data); state becomes HELD and wait count 0.
  - Earliest register-file write is cycle t+1, i.e. 1-cycle latency.
  - McReady = (state==EMPTY). There is no accept while the buffer is valid.
  - McValid with McRd==0 is accepted and dropped; state stays EMPTY.
- Port mux, combinational, in priority order:
  1. If PW: RegWriteRF=1, RdRF=RdW, WDataRF=ResultW.
  2. Else if buffer valid: RegWriteRF=1, RdRF=buffer rd, WDataRF=buffer data; the buffer drains at this edge and state goes to EMPTY.
  3. Else: RegWriteRF=0, RdRF=RdW, WDataRF=ResultW.
- WAW squash:
  - If the buffer is valid, PW is true and RdW equals the buffer rd, the buffer is invalidated at this edge and state goes to EMPTY.
  - SquashW=1 in that cycle (combinational).
  - Rationale: the pipeline write is younger.
- Blocked cycle (buffer valid, PW, rd differs): the wait count increments, saturating at MAX_WAIT.
  - HELD → FORCE on the edge where the incremented count reaches MAX_WAIT.
- FORCE:
  - Stays until the buffer drains or is squashed, then goes to EMPTY and the count is cleared.
  - If PW persists despite StallReq (instruction already in W), the buffer keeps waiting and StallReq stays high.
- PendValid = state!=EMPTY. PendRd = buffer rd while valid, else 0.
- Reset mid-operation discards the buffered result without a write. The multi-cycle unit must be reset together with this block.

Decomposition:
- Shared package wb_pkg holds:
  - the state enum wb_state_e {EMPTY, HELD, FORCE};
  - the constants REG_AW and ZERO_REG.
- One natural sub-module, wb_hold_buf: the one-entry rd/data register with load and clear, plus the saturating wait counter.
- The arbitration mux and FSM stay in the top module.

Test Plan:
- Reset check: assert rst mid-HELD with McRd=5 buffered. Then McReady=1, PendValid=0, StallReq=0 immediately, and no write of x5 ever occurs.
- Free port, single-cycle latency: McValid, McRd=3, McData=0xDEADBEEF at cycle t, with RegWriteW=0 at t+1. At t+1: RegWriteRF=1, RdRF=3, WDataRF=0xDEADBEEF. Then PendValid=0 at t+2.
- Priority and force: buffer holds rd=7, and the pipeline writes rd=9 for 4 consecutive cycles (MAX_WAIT=4).
  - Pipeline writes go through in all 4 cycles.
  - StallReq rises after the 4th edge.
  - With RegWriteW=0 next cycle: x7 is written, StallReq clears the following cycle.
- WAW squash: buffer holds rd=12, pipeline writes rd=12 with 0x55. Then RdRF=12, WDataRF=0x55, SquashW=1 for one cycle, state returns to EMPTY, and the buffered value is never written.
- rd zero handling:
  - McRd=0 accepted → no write, McReady stays 1.
  - RegWriteW=1 with RdW=0 while buffer holds rd=4 → the buffer drains to x4 in that cycle.
- Back-pressure: McValid held high with a full buffer and the port blocked. McReady=0 until the drain cycle; the second result is accepted on the edge after the drain and written at the first free cycle after that.
